// File: rtl/gpio_cfg_defs.sv
// Shared definitions for the GPIO pad configuration chain: loader state encodings,
// default chain geometry and the pad-config bit-field layout used by housekeeping.
package gpio_cfg_defs;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCrst  = 3'd1,
    StFetch = 3'd2,
    StShift = 3'd3,
    StLoad  = 3'd4,
    StDone  = 3'd5
  } loader_state_e;

  localparam int unsigned DefNumPads  = 19;
  localparam int unsigned DefCfgWidth = 13;

  // Bit offsets within one pad configuration word (LSB = 0).
  localparam int unsigned PadMgmtEnBit   = 0;
  localparam int unsigned PadOutDisBit   = 1;
  localparam int unsigned PadHoldOvrBit  = 2;
  localparam int unsigned PadInpDisBit   = 3;
  localparam int unsigned PadIbModeBit   = 4;
  localparam int unsigned PadAnaEnBit    = 5;
  localparam int unsigned PadAnaSelBit   = 6;
  localparam int unsigned PadAnaPolBit   = 7;
  localparam int unsigned PadSlowBit     = 8;
  localparam int unsigned PadTripBit     = 9;
  localparam int unsigned PadDmLsb       = 10;
  localparam int unsigned PadDmWidth     = 3;

endpackage

// File: rtl/serial_tick_gen.sv
// Half-period timer for the serial chain: emits a one-cycle phase_end tick every CLK_DIV
// cycles, restarting from zero whenever clear is asserted.
module serial_tick_gen #(
  parameter int unsigned CLK_DIV = 2,
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic phase_end
);

  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign phase_end = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || phase_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Loads the GPIO pad configuration chain: resets it, shifts one word per pad (highest pad
// first, MSB first) and then strobes the parallel load.
module gpio_serial_loader
  import gpio_cfg_defs::*;
#(
  parameter int unsigned NUM_PADS  = DefNumPads,
  parameter int unsigned CFG_WIDTH = DefCfgWidth,
  parameter int unsigned CLK_DIV   = 2,
  localparam int unsigned AddrW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AddrW-1:0]     cfg_addr,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  output logic                 serial_resetn,
  output logic                 serial_clock,
  output logic                 serial_data,
  output logic                 serial_load
);

  localparam int unsigned BitW = $clog2(CFG_WIDTH + 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(CFG_WIDTH - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_PADS - 1);

  loader_state_e         state_q, state_d;
  logic [AddrW-1:0]      addr_q, addr_d;
  logic [CFG_WIDTH-1:0]  shreg_q, shreg_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  phase_q, phase_d;
  logic                  init_q;
  logic                  phase_end;
  logic                  state_chg;

  assign state_chg = (state_d != state_q);

  serial_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (state_chg),
    .phase_end (phase_end)
  );

  // phase_q: 0 = first half-period, 1 = second half-period of the current bit/interval.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    phase_d = phase_q ^ phase_end;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCrst;
          addr_d  = LastAddr;
        end
      end
      StCrst: begin
        if (phase_end && phase_q) state_d = StFetch;
      end
      StFetch: begin
        shreg_d = cfg_data;
        state_d = StShift;
      end
      StShift: begin
        if (phase_end && phase_q) begin
          shreg_d = {shreg_q[CFG_WIDTH-2:0], 1'b0};
          bit_d   = bit_q + BitW'(1);
          if (bit_q == LastBit) begin
            if (addr_q == '0) begin
              state_d = StLoad;
            end else begin
              addr_d  = addr_q - AddrW'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StLoad: begin
        if (phase_end && phase_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (state_chg) begin
      phase_d = 1'b0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      init_q  <= 1'b1;
    end
  end

  // Chain stays in reset until the first clock after release, and again during CRST.
  assign serial_resetn = init_q && (state_q != StCrst);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign serial_load   = (state_q == StLoad);
  assign serial_clock  = (state_q == StShift) && phase_q;
  assign serial_data   = (state_q == StShift) && shreg_q[CFG_WIDTH-1];
  assign cfg_addr      = addr_q;

endmodule
